// File: rtl/pitch_slot_scheduler_pkg.sv
// Shared synth definitions for the pitch slot scheduler: default voice and
// oscillator counts, slot and pitch word widths, and the sequencer state codes.
package pitch_slot_scheduler_pkg;

    // Default voice/oscillator set used across the synth
    localparam int VOICES_DEF = 8;
    localparam int V_OSC_DEF  = 4;

    // Slot index width for the default set (V_WIDTH + O_WIDTH)
    localparam int SLOT_W     = 5;

    // Width of one pitch table word
    localparam int PITCH_W    = 24;

    // Sequencer states
    localparam int         STATE_W      = 3;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETTLE    = 3'd1;
    localparam logic [2:0] ST_CAPTURE   = 3'd2;
    localparam logic [2:0] ST_KEY_SETUP = 3'd3;
    localparam logic [2:0] ST_KEY_PULSE = 3'd4;
    localparam logic [2:0] ST_CFG_PULSE = 3'd5;
    localparam logic [2:0] ST_CFG_HOLD  = 3'd6;

endpackage

// File: rtl/pitch_slot_scheduler.sv
// Time-shares one pitch_control datapath across all voice/oscillator slots.
// Each slot index is held for SETTLE cycles, then the datapath result is
// written into the pitch table. Key-assignment and parameter-write requests
// are only taken between slots and are turned into clean note_on / write
// pulses with registered address/data around them.
// Optional: define PITCH_SCHED_SETTLE_CHK_EN to add a sticky settle_err flag
// that catches a datapath result still moving during the capture cycle.
module pitch_slot_scheduler
    import pitch_slot_scheduler_pkg::*;
#(
    parameter int VOICES    = VOICES_DEF,
    parameter int V_OSC     = V_OSC_DEF,
    parameter int V_WIDTH   = 3,
    parameter int O_WIDTH   = 2,
    parameter int OE_WIDTH  = 1,
    parameter int E_WIDTH   = O_WIDTH + OE_WIDTH,
    parameter int SETTLE    = 4
) (
    input  logic                         sCLK_XVXENVS,
    input  logic                         iRST,
    input  logic                         run,
    input  logic                         key_req,
    input  logic [V_WIDTH-1:0]           key_adr,
    input  logic [7:0]                   key_val,
    output logic                         key_ack,
    input  logic                         cfg_req,
    input  logic [6:0]                   cfg_adr,
    input  logic [7:0]                   cfg_data,
    input  logic                         cfg_osc,
    output logic                         cfg_ack,
    output logic [V_WIDTH+E_WIDTH-1:0]   xxxx,
    output logic [V_WIDTH-1:0]           cur_key_adr,
    output logic [7:0]                   cur_key_val,
    output logic                         note_on,
    output logic [6:0]                   adr,
    output logic [7:0]                   data,
    output logic                         write,
    output logic                         osc_sel,
    output logic                         com_sel,
    input  logic [PITCH_W-1:0]           osc_pitch_val,
    output logic                         pitch_we,
    output logic [V_WIDTH+O_WIDTH-1:0]   pitch_adr,
    output logic [PITCH_W-1:0]           pitch_data,
    output logic                         frame_done,
    output logic                         settle_err
);

    localparam int                 S_W       = V_WIDTH + O_WIDTH;
    localparam int                 CNT_W     = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam logic [S_W-1:0]     LAST_SLOT = S_W'(VOICES * V_OSC - 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [S_W-1:0]     slot_r;

    logic                 key_ack_r;
    logic                 cfg_ack_r;
    logic [V_WIDTH-1:0]   cur_key_adr_r;
    logic [7:0]           cur_key_val_r;
    logic                 note_on_r;
    logic [6:0]           adr_r;
    logic [7:0]           data_r;
    logic                 write_r;
    logic                 osc_sel_r;
    logic                 com_sel_r;
    logic                 pitch_we_r;
    logic [S_W-1:0]       pitch_adr_r;
    logic [PITCH_W-1:0]   pitch_data_r;
    logic                 frame_done_r;

    // Next-state decode; requests are only looked at on slot boundaries
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE, ST_CAPTURE: begin
                if (key_req) begin
                    state_nx_s = ST_KEY_SETUP;
                end else if (cfg_req) begin
                    state_nx_s = ST_CFG_PULSE;
                end else if (run) begin
                    state_nx_s = ST_SETTLE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nx_s = ST_CAPTURE;
                end else begin
                    state_nx_s = ST_SETTLE;
                end
            end
            ST_KEY_SETUP: begin
                state_nx_s = ST_KEY_PULSE;
            end
            ST_KEY_PULSE: begin
                if (cfg_req) begin
                    state_nx_s = ST_CFG_PULSE;
                end else if (run) begin
                    state_nx_s = ST_SETTLE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CFG_PULSE: begin
                state_nx_s = ST_CFG_HOLD;
            end
            ST_CFG_HOLD: begin
                if (run) begin
                    state_nx_s = ST_SETTLE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, settle countdown and slot counter; slot only advances after capture
    always_ff @(posedge sCLK_XVXENVS or posedge iRST) begin
        if (iRST) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            slot_r  <= {S_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if ((state_nx_s == ST_SETTLE) && (state_r != ST_SETTLE)) begin
                cnt_r <= CNT_LOAD;
            end else if ((state_r == ST_SETTLE) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
            if (state_r == ST_CAPTURE) begin
                slot_r <= (slot_r == LAST_SLOT) ? {S_W{1'b0}} : (slot_r + S_W'(1));
            end
        end
    end

    // Registered outputs decoded from the next state so they line up with the state
    always_ff @(posedge sCLK_XVXENVS or posedge iRST) begin
        if (iRST) begin
            key_ack_r     <= 1'b0;
            cfg_ack_r     <= 1'b0;
            cur_key_adr_r <= {V_WIDTH{1'b0}};
            cur_key_val_r <= 8'h00;
            note_on_r     <= 1'b0;
            adr_r         <= 7'h00;
            data_r        <= 8'h00;
            write_r       <= 1'b0;
            osc_sel_r     <= 1'b0;
            com_sel_r     <= 1'b0;
            pitch_we_r    <= 1'b0;
            pitch_adr_r   <= {S_W{1'b0}};
            pitch_data_r  <= {PITCH_W{1'b0}};
            frame_done_r  <= 1'b0;
        end else begin
            note_on_r    <= (state_nx_s == ST_KEY_PULSE);
            key_ack_r    <= (state_nx_s == ST_KEY_PULSE);
            write_r      <= (state_nx_s == ST_CFG_PULSE);
            cfg_ack_r    <= (state_nx_s == ST_CFG_HOLD);
            pitch_we_r   <= (state_nx_s == ST_CAPTURE);
            frame_done_r <= (state_nx_s == ST_CAPTURE) && (slot_r == LAST_SLOT);
            // Key fields settle one cycle ahead of the note_on rise
            if (state_nx_s == ST_KEY_SETUP) begin
                cur_key_adr_r <= key_adr;
                cur_key_val_r <= key_val;
            end
            // Parameter address/data/bank stay put through the write fall and after
            if (state_nx_s == ST_CFG_PULSE) begin
                adr_r     <= cfg_adr;
                data_r    <= cfg_data;
                osc_sel_r <= cfg_osc;
                com_sel_r <= ~cfg_osc;
            end
            // Pitch word is taken on the last settle cycle and presented during capture
            if (state_nx_s == ST_CAPTURE) begin
                pitch_adr_r  <= slot_r;
                pitch_data_r <= osc_pitch_val;
            end
        end
    end

`ifdef PITCH_SCHED_SETTLE_CHK_EN
    logic settle_err_r;

    // Sticky flag: pitch_data_r holds the last-settle-cycle sample, so any
    // difference from the live value during capture means the datapath had not settled
    always_ff @(posedge sCLK_XVXENVS or posedge iRST) begin
        if (iRST) begin
            settle_err_r <= 1'b0;
        end else if ((state_r == ST_CAPTURE) && (osc_pitch_val != pitch_data_r)) begin
            settle_err_r <= 1'b1;
        end
    end

    assign settle_err = settle_err_r;
`else
    assign settle_err = 1'b0;
`endif

    assign xxxx        = {slot_r, {OE_WIDTH{1'b0}}};
    assign key_ack     = key_ack_r;
    assign cfg_ack     = cfg_ack_r;
    assign cur_key_adr = cur_key_adr_r;
    assign cur_key_val = cur_key_val_r;
    assign note_on     = note_on_r;
    assign adr         = adr_r;
    assign data        = data_r;
    assign write       = write_r;
    assign osc_sel     = osc_sel_r;
    assign com_sel     = com_sel_r;
    assign pitch_we    = pitch_we_r;
    assign pitch_adr   = pitch_adr_r;
    assign pitch_data  = pitch_data_r;
    assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_pitch_slot_scheduler.sv
// Self-checking bench for pitch_slot_scheduler: scoreboard of expected pitch
// table writes, a table of key/cfg requests applied while idle, and
// hand-written sequences for mid-settle requests, run drop, reset during a
// pulse and the optional settle checker (PITCH_SCHED_SETTLE_CHK_EN).
module tb_pitch_slot_scheduler;

    logic        sCLK_XVXENVS = 1'b0;
    logic        iRST = 1'b1;
    logic        run = 1'b0;
    logic        key_req = 1'b0;
    logic [2:0]  key_adr = 3'd0;
    logic [7:0]  key_val = 8'd0;
    logic        key_ack;
    logic        cfg_req = 1'b0;
    logic [6:0]  cfg_adr = 7'd0;
    logic [7:0]  cfg_data = 8'd0;
    logic        cfg_osc = 1'b0;
    logic        cfg_ack;
    logic [5:0]  xxxx;
    logic [2:0]  cur_key_adr;
    logic [7:0]  cur_key_val;
    logic        note_on;
    logic [6:0]  adr;
    logic [7:0]  data;
    logic        write;
    logic        osc_sel;
    logic        com_sel;
    logic [23:0] osc_pitch_val;
    logic        pitch_we;
    logic [4:0]  pitch_adr;
    logic [23:0] pitch_data;
    logic        frame_done;
    logic        settle_err;
    logic [23:0] glitch = 24'h0;

    pitch_slot_scheduler dut (
        .sCLK_XVXENVS (sCLK_XVXENVS), .iRST (iRST), .run (run),
        .key_req (key_req), .key_adr (key_adr), .key_val (key_val), .key_ack (key_ack),
        .cfg_req (cfg_req), .cfg_adr (cfg_adr), .cfg_data (cfg_data), .cfg_osc (cfg_osc),
        .cfg_ack (cfg_ack), .xxxx (xxxx), .cur_key_adr (cur_key_adr),
        .cur_key_val (cur_key_val), .note_on (note_on), .adr (adr), .data (data),
        .write (write), .osc_sel (osc_sel), .com_sel (com_sel),
        .osc_pitch_val (osc_pitch_val), .pitch_we (pitch_we), .pitch_adr (pitch_adr),
        .pitch_data (pitch_data), .frame_done (frame_done), .settle_err (settle_err)
    );

    always #5 sCLK_XVXENVS = ~sCLK_XVXENVS;

    // Slot-dependent datapath result
    function automatic logic [23:0] pat(input logic [4:0] s);
        return {s, 3'b101, s, 3'b010, s, 3'b110};
    endfunction

    assign osc_pitch_val = pat(xxxx[5:1]) ^ glitch;

    typedef struct {
        logic [4:0]  adr;
        logic [23:0] data;
        logic        fd;
    } cap_t;

    typedef struct {
        logic       is_key;
        logic [2:0] kadr;
        logic [7:0] kval;
        logic       osc;
        logic [6:0] cadr;
        logic [7:0] cdata;
    } vec_t;

    cap_t sb_q[$];
    vec_t tbl[5];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_we = 0;
    int   exp_period = 0;
    logic exp_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_slot(input int s);
        cap_t e;
        e.adr  = 5'(s);
        e.data = pat(5'(s));
        e.fd   = (s == 31);
        sb_q.push_back(e);
    endtask

    // One clock; sample just after the edge and score any pitch table write
    task automatic tick();
        cap_t e;
        @(posedge sCLK_XVXENVS);
        #1;
        cyc++;
        if (pitch_we) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_we", 32'(pitch_adr), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("cap_adr", 32'(pitch_adr), 32'(e.adr));
                chk("cap_data", 32'(pitch_data), 32'(e.data));
                chk("cap_frame_done", 32'(frame_done), 32'(e.fd));
                if (exp_period != 0) chk("slot_period", 32'(cyc - last_we), 32'(exp_period));
            end
            last_we = cyc;
        end else if (frame_done) begin
            chk("stray_frame_done", 32'(frame_done), 32'd0);
        end
    endtask

    task automatic run_until_empty(input int bound);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("capture_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef PITCH_SCHED_SETTLE_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        tbl[0] = '{is_key: 1'b0, kadr: 3'd0, kval: 8'd0,   osc: 1'b1, cadr: 7'h05, cdata: 8'h3C};
        tbl[1] = '{is_key: 1'b0, kadr: 3'd0, kval: 8'd0,   osc: 1'b0, cadr: 7'h7F, cdata: 8'hFF};
        tbl[2] = '{is_key: 1'b1, kadr: 3'd7, kval: 8'd127, osc: 1'b0, cadr: 7'h00, cdata: 8'h00};
        tbl[3] = '{is_key: 1'b0, kadr: 3'd0, kval: 8'd0,   osc: 1'b1, cadr: 7'h00, cdata: 8'h01};
        tbl[4] = '{is_key: 1'b1, kadr: 3'd1, kval: 8'd36,  osc: 1'b0, cadr: 7'h00, cdata: 8'h00};

        // Reset state
        tick();
        tick();
        chk("rst_xxxx", 32'(xxxx), 32'd0);
        chk("rst_pitch_we", 32'(pitch_we), 32'd0);
        chk("rst_note_on", 32'(note_on), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_acks", 32'({key_ack, cfg_ack, osc_sel, com_sel}), 32'd0);
        chk("rst_settle_err", 32'(settle_err), 32'd0);

        // Full frame with wrap
        run = 1'b1;
        iRST = 1'b0;
        push_slot(0);
        run_until_empty(20);
        exp_period = 5;
        for (int s = 1; s < 32; s++) push_slot(s);
        for (int s = 0; s < 3; s++) push_slot(s);
        run_until_empty(250);
        chk("frame_settle_err", 32'(settle_err), 32'd0);

        // Key request mid-settle of slot 3
        push_slot(3);
        tick();
        tick();
        key_req = 1'b1; key_adr = 3'd5; key_val = 8'd60;
        tick();
        chk("key_wait_note_on", 32'(note_on), 32'd0);
        run_until_empty(10);
        tick();
        chk("key_setup_note_on", 32'(note_on), 32'd0);
        chk("key_setup_val", 32'({cur_key_adr, cur_key_val}), 32'({3'd5, 8'd60}));
        tick();
        chk("key_pulse_note_on", 32'(note_on), 32'd1);
        chk("key_pulse_ack", 32'(key_ack), 32'd1);
        chk("key_pulse_val", 32'(cur_key_val), 32'd60);
        key_req = 1'b0;
        push_slot(4);
        exp_period = 7;
        tick();
        chk("key_after_note_on", 32'({note_on, key_ack}), 32'd0);
        chk("key_resume_slot", 32'(xxxx), 32'd8);
        run_until_empty(10);

        // Simultaneous key and cfg at slot 4 capture
        key_req = 1'b1; key_adr = 3'd2; key_val = 8'd72;
        cfg_req = 1'b1; cfg_osc = 1'b1; cfg_adr = 7'h11; cfg_data = 8'h42;
        tick();
        chk("kc_setup_val", 32'(cur_key_val), 32'd72);
        tick();
        chk("kc_note_on", 32'({note_on, key_ack, write}), 32'b110);
        key_req = 1'b0;
        tick();
        chk("kc_write_hi", 32'({note_on, write, cfg_ack}), 32'b010);
        chk("kc_adr_data", 32'({adr, data}), 32'({7'h11, 8'h42}));
        chk("kc_sel", 32'({osc_sel, com_sel}), 32'b10);
        tick();
        chk("kc_write_lo", 32'({write, cfg_ack}), 32'b01);
        chk("kc_hold", 32'({adr, data, osc_sel, com_sel}), 32'({7'h11, 8'h42, 2'b10}));
        cfg_req = 1'b0;
        push_slot(5);
        exp_period = 9;
        run_until_empty(12);

        // run dropped during slot 10 settle
        exp_period = 5;
        for (int s = 6; s < 10; s++) push_slot(s);
        run_until_empty(25);
        push_slot(10);
        tick();
        tick();
        run = 1'b0;
        run_until_empty(10);
        exp_period = 0;
        repeat (6) tick();
        chk("idle_slot_kept", 32'(xxxx), 32'd22);

        // Requests serviced from IDLE without scanning
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].is_key) begin
                key_req = 1'b1; key_adr = tbl[i].kadr; key_val = tbl[i].kval;
                tick();
                chk("tbl_key_setup", 32'({note_on, cur_key_adr, cur_key_val}),
                    32'({1'b0, tbl[i].kadr, tbl[i].kval}));
                tick();
                chk("tbl_key_pulse", 32'({note_on, key_ack}), 32'b11);
                key_req = 1'b0;
                tick();
                chk("tbl_key_done", 32'({note_on, key_ack}), 32'b00);
            end else begin
                cfg_req = 1'b1; cfg_osc = tbl[i].osc; cfg_adr = tbl[i].cadr; cfg_data = tbl[i].cdata;
                tick();
                chk("tbl_cfg_pulse", 32'({write, cfg_ack, adr, data, osc_sel, com_sel}),
                    32'({2'b10, tbl[i].cadr, tbl[i].cdata, tbl[i].osc, ~tbl[i].osc}));
                tick();
                chk("tbl_cfg_hold", 32'({write, cfg_ack, adr, data}),
                    32'({2'b01, tbl[i].cadr, tbl[i].cdata}));
                cfg_req = 1'b0;
                tick();
                chk("tbl_cfg_done", 32'({write, cfg_ack}), 32'b00);
            end
        end

        // Resume at slot 11, single slot
        run = 1'b1;
        push_slot(11);
        tick();
        tick();
        run = 1'b0;
        run_until_empty(10);

        // Reset asserted during KEY_PULSE
        key_req = 1'b1; key_adr = 3'd6; key_val = 8'd99;
        tick();
        tick();
        chk("rk_note_on_before", 32'(note_on), 32'd1);
        iRST = 1'b1;
        #1;
        chk("rk_note_on", 32'({note_on, key_ack}), 32'b00);
        chk("rk_outputs", 32'({cur_key_val, xxxx, write, pitch_we}), 32'd0);
        key_req = 1'b0;
        run = 1'b1;
        tick();
        tick();
        iRST = 1'b0;
        push_slot(0);
        tick();
        tick();
        run = 1'b0;
        run_until_empty(10);

        // Datapath result moving during capture
        push_slot(1);
        run = 1'b1;
        repeat (4) tick();
        run = 1'b0;
        tick();
        chk("sc_capture_we", 32'(pitch_we), 32'd1);
        glitch = 24'h000100;
        tick();
        glitch = 24'h0;
        chk("sc_settle_err", 32'(settle_err), 32'(exp_err));
        repeat (3) tick();
        chk("sc_settle_err_sticky", 32'(settle_err), 32'(exp_err));
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pitch_slot_scheduler.md
# pitch_slot_scheduler

Sequencer that time-shares one `pitch_control` datapath across all VOICES×V_OSC oscillator slots. It steps the slot index, holds it for a programmable settle window, and captures `osc_pitch_val` into the per-slot pitch table write port. It also serialises key-assignment and parameter-write requests into the clean edge-triggered `note_on` / `write` pulses the datapath expects. It never issues them mid-capture.

## Interface
Parameters:
- VOICES, 8, voice count
- V_OSC, 4, oscillators per voice
- V_WIDTH, 3, log2(VOICES)
- O_WIDTH, 2, log2(V_OSC)
- OE_WIDTH, 1, oscillator-envelope sub-index width (driven 0)
- E_WIDTH, O_WIDTH+OE_WIDTH
- SETTLE, 4, cycles slot index is held before capture (≥2)

Ports (one clock; reset asynchronous, active-high):
- sCLK_XVXENVS  in  1  system clock
- iRST  in  1  asynchronous active-high reset
- run  in  1  level; enables slot scanning
- key_req  in  1  key-assignment request, level until ack
- key_adr  in  V_WIDTH  voice to assign
- key_val  in  8  MIDI key number
- key_ack  out  1  one-cycle acknowledge
- cfg_req  in  1  parameter-write request, level until ack
- cfg_adr  in  7  parameter address
- cfg_data  in  8  parameter value
- cfg_osc  in  1  1 = oscillator bank, 0 = common bank
- cfg_ack  out  1  one-cycle acknowledge
- xxxx  out  V_WIDTH+E_WIDTH  slot index to datapath {vx, ox, oe=0}
- cur_key_adr  out  V_WIDTH; cur_key_val  out  8; note_on  out  1
- adr  out  7; data  out  8; write  out  1; osc_sel  out  1; com_sel  out  1
- osc_pitch_val  in  24  datapath result
- pitch_we  out  1; pitch_adr  out  V_WIDTH+O_WIDTH; pitch_data  out  24
- frame_done  out  1  pulse at capture of last slot
- settle_err  out  1  sticky; only when PITCH_SCHED_SETTLE_CHK_EN is defined

## Operation
- States: IDLE, SETTLE, CAPTURE, KEY_SETUP, KEY_PULSE, CFG_PULSE, CFG_HOLD.
- Slot counter `slot[V_WIDTH+O_WIDTH-1:0]`. `xxxx = {slot, OE_WIDTH'b0}`.
- IDLE: if key_req → KEY_SETUP; else if cfg_req → CFG_PULSE; else if run → SETTLE.
- SETTLE: hold slot for SETTLE cycles (counter SETTLE-1..0), then → CAPTURE.
- CAPTURE (1 cycle):
  - pitch_we=1, pitch_adr=slot, pitch_data=osc_pitch_val.
  - frame_done=1 when slot = VOICES*V_OSC-1.
  - slot increments and wraps to 0.
  - Next state: key_req → KEY_SETUP; else cfg_req → CFG_PULSE; else run → SETTLE; else IDLE.
- KEY_SETUP: cur_key_adr/val loaded from key_adr/val, note_on=0.
- KEY_PULSE: note_on=1, key_ack=1.
  - Next: cfg_req → CFG_PULSE; else run → SETTLE; else IDLE.
  - note_on returns to 0 on the following cycle.
- CFG_PULSE: adr/data loaded; osc_sel=cfg_osc, com_sel=~cfg_osc; write=1.
- CFG_HOLD: write=0 (datapath latches on this falling edge), adr/data/sel held, cfg_ack=1.
  - Next: run → SETTLE; else IDLE.
- Requests are only sampled at slot boundaries (IDLE, CAPTURE exit, KEY_PULSE exit). A slot is never abandoned mid-settle.
- Simultaneous key_req and cfg_req: key first, cfg serviced back-to-back.
- run deasserted mid-slot: the current slot completes through CAPTURE, then IDLE. slot is retained.
- Requester drops req the cycle after ack. req still high after ack is treated as a new request.

## Timing
- Reset values: all outputs 0, slot=0, state IDLE, settle_err=0. Reset takes effect immediately, including mid-pulse.
- Slot period SETTLE+1 cycles. Default frame = 32×5 = 160 cycles with no events.
- Key event adds 2 cycles; cfg event adds 2 cycles. Both serviced back-to-back add 4.
- Latency req→ack: at most SETTLE+1 cycles to reach a boundary, plus 2.
- cur_key_*/adr/data/sel registered; stable ≥1 cycle before note_on rise and through write fall.

## Configuration
- PITCH_SCHED_SETTLE_CHK_EN defined:
  - Register osc_pitch_val on the last SETTLE cycle.
  - In CAPTURE, compare it with the live osc_pitch_val; any mismatch sets settle_err.
  - settle_err clears only on reset.
- Undefined: compare logic and register absent; settle_err tied 0.

## Structure
- Shared synth package holds the state enum, slot-width localparam (V_WIDTH+O_WIDTH) and the 24-bit pitch word width. VOICES/V_OSC defaults come from the existing synth parameter set.
- Single module; no sub-module. The optional settle checker is an ifdef'd block.

## Test plan
- Reset, run=1, osc_pitch_val=slot-dependent pattern → 32 pitch_we pulses every 5 cycles, pitch_adr 0..31, frame_done at adr 31, wrap to 0.
- key_req (adr 5, val 60) asserted mid-settle of slot 3 → no action until slot 3 CAPTURE. Then KEY_SETUP; note_on high exactly 1 cycle with cur_key_val=60; key_ack in the same cycle; scanning resumes at slot 4.
- key_req and cfg_req (osc, adr 0x11, data 0x42) in the same cycle → note_on pulse, then write=1 one cycle then 0 with adr=0x11, data=0x42, osc_sel=1, com_sel=0; cfg_ack on the write-low cycle.
- run=0 during slot 10 settle → slot 10 captured, then IDLE. run=1 resumes at slot 11. A cfg_req while IDLE is serviced without scanning.
- iRST asserted during KEY_PULSE → note_on, key_ack, all outputs 0 immediately. After release, scan restarts at slot 0.
- With PITCH_SCHED_SETTLE_CHK_EN: osc_pitch_val changes on the CAPTURE cycle → settle_err=1 and stays set. Without the macro, the same stimulus → settle_err=0.
